axi_sram_slave: RTL and testbench

AXI4 slave endpoint that sits directly downstream of the AXI master multiplexer's single S_AXI output port. It converts AXI read and write bursts into accesses on a single-port synchronous SRAM with 1-cycle read latency. Bursts are serviced one at a time. It supports FIXED, INCR and WRAP bursts with full read throughput (one beat per cycle).

---
 rtl/axi_sram_slave_if.sv | 87 ++++++++
 rtl/axi_sram_slave.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the master multiplexer output and the SRAM slave.
// Signal names keep the S_AXI_* spelling of the multiplexer port list.
interface axi_sram_slave_if #(
    parameter int C_AXI_ID_WIDTH   = 2,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32
);
    // Write address channel
    logic [C_AXI_ID_WIDTH-1:0]     S_AXI_AWID;
    logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [7:0]                    S_AXI_AWLEN;
    logic [2:0]                    S_AXI_AWSIZE;
    logic [1:0]                    S_AXI_AWBURST;
    logic                          S_AXI_AWLOCK;
    logic [3:0]                    S_AXI_AWCACHE;
    logic [2:0]                    S_AXI_AWPROT;
    logic [3:0]                    S_AXI_AWQOS;
    logic [3:0]                    S_AXI_AWUSER;
    logic                          S_AXI_AWVALID;
    logic                          S_AXI_AWREADY;
    // Write data channel
    logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                          S_AXI_WLAST;
    logic                          S_AXI_WVALID;
    logic                          S_AXI_WREADY;
    // Write response channel
    logic [C_AXI_ID_WIDTH-1:0]     S_AXI_BID;
    logic [1:0]                    S_AXI_BRESP;
    logic                          S_AXI_BVALID;
    logic                          S_AXI_BREADY;
    // Read address channel
    logic [C_AXI_ID_WIDTH-1:0]     S_AXI_ARID;
    logic [C_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [7:0]                    S_AXI_ARLEN;
    logic [2:0]                    S_AXI_ARSIZE;
    logic [1:0]                    S_AXI_ARBURST;
    logic                          S_AXI_ARLOCK;
    logic [3:0]                    S_AXI_ARCACHE;
    logic [2:0]                    S_AXI_ARPROT;
    logic [3:0]                    S_AXI_ARQOS;
    logic [3:0]                    S_AXI_ARUSER;
    logic                          S_AXI_ARVALID;
    logic                          S_AXI_ARREADY;
    // Read data channel
    logic [C_AXI_ID_WIDTH-1:0]     S_AXI_RID;
    logic [C_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                    S_AXI_RRESP;
    logic                          S_AXI_RLAST;
    logic [3:0]                    S_AXI_RUSER;
    logic                          S_AXI_RVALID;
    logic                          S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER,
               S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER,
               S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER,
               S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARUSER,
               S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave that services one burst at a time from a single-port synchronous
// SRAM with one cycle of read latency. FIXED/INCR/WRAP bursts, full read rate.
module axi_sram_slave #(
    parameter int C_AXI_ID_WIDTH   = 2,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH   = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_sram_slave_if.slave               s_axi,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]   mem_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [C_AXI_DATA_WIDTH-1:0]   mem_rdata
);
    localparam int DW         = C_AXI_DATA_WIDTH;
    localparam int AW         = C_AXI_ADDR_WIDTH;
    localparam int WORD_SHIFT = (DW == 64) ? 3 : 2;
    localparam logic [2:0] MAX_SIZE = 3'(WORD_SHIFT);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_BURST} state_t;

    state_t                    state, state_nx;
    logic [C_AXI_ID_WIDTH-1:0] id_q;
    logic [AW-1:0]             addr_q;
    logic [7:0]                len_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      err_q;
    logic                      wlast_err_q;
    logic [7:0]                beat_q;
    logic                      rr_rd_last;    // read won the last contested grant
    logic                      issue_done_q;  // every read beat of the burst sent to SRAM

    // Read return path: p_* is the beat whose data sits on mem_rdata this
    // cycle, s_* holds a beat that was presented but not taken.
    logic                      p_valid, p_last;
    logic                      s_valid, s_last;
    logic [DW-1:0]             s_data;

    logic                      aw_grant, ar_grant, both_valid;
    logic                      w_beat, rd_issue, rd_pop;
    logic                      rd_valid, rd_last;
    logic [DW-1:0]             rd_data;

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_bad;
        wrap_bad = (burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return (size > MAX_SIZE) || wrap_bad || (burst == BURST_RSVD);
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] incr;
        logic [AW-1:0] mask;
        incr = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + incr) & mask);
            default:     return addr + incr;
        endcase
    endfunction

    assign both_valid = s_axi.S_AXI_AWVALID && s_axi.S_AXI_ARVALID;
    assign w_beat     = (state == WR_DATA) && s_axi.S_AXI_WVALID;
    assign mem_addr   = MEM_ADDR_WIDTH'(addr_q >> WORD_SHIFT);

    // Next-state, arbitration, SRAM strobes and channel outputs
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nx  = state;
        aw_grant  = 1'b0;
        ar_grant  = 1'b0;
        rd_issue  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wstrb = '0;

        rd_valid = s_valid || p_valid;
        rd_last  = s_valid ? s_last : p_last;
        rd_data  = s_valid ? s_data : ((p_valid && !err_q) ? mem_rdata : '0);
        rd_pop   = rd_valid && s_axi.S_AXI_RREADY;

        case (state)
            IDLE: begin
                // NOTE: readies are combinational, so they are gated by rst_n to stay 0 in reset.
                if (rst_n) begin
                    if (both_valid) begin
                        aw_grant = rr_rd_last;
                        ar_grant = !rr_rd_last;
                    end else begin
                        aw_grant = s_axi.S_AXI_AWVALID;
                        ar_grant = s_axi.S_AXI_ARVALID;
                    end
                end
                if (aw_grant)      state_nx = WR_DATA;
                else if (ar_grant) state_nx = RD_BURST;
            end
            WR_DATA: begin
                if (w_beat) begin
                    mem_req   = !err_q;
                    mem_we    = !err_q;
                    mem_wdata = err_q ? '0 : s_axi.S_AXI_WDATA;
                    mem_wstrb = err_q ? '0 : s_axi.S_AXI_WSTRB;
                    if (beat_q == len_q) state_nx = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi.S_AXI_BREADY) state_nx = IDLE;
            end
            RD_BURST: begin
                // Occupancy of p/s never exceeds one, so a slot is free next
                // cycle exactly when nothing is held or the held beat leaves now.
                rd_issue = !issue_done_q && (!rd_valid || s_axi.S_AXI_RREADY);
                mem_req  = rd_issue && !err_q;
                if (rd_pop && rd_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        s_axi.S_AXI_AWREADY = aw_grant;
        s_axi.S_AXI_ARREADY = ar_grant;
        s_axi.S_AXI_WREADY  = (state == WR_DATA);
        s_axi.S_AXI_BVALID  = (state == WR_RESP);
        s_axi.S_AXI_BID     = id_q;
        s_axi.S_AXI_BRESP   = (err_q || wlast_err_q) ? RESP_SLVERR : RESP_OKAY;
        s_axi.S_AXI_RVALID  = rd_valid;
        s_axi.S_AXI_RID     = id_q;
        s_axi.S_AXI_RDATA   = rd_data;
        s_axi.S_AXI_RRESP   = err_q ? RESP_SLVERR : RESP_OKAY;
        s_axi.S_AXI_RLAST   = rd_valid && rd_last;
        s_axi.S_AXI_RUSER   = 4'h0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Burst context: latch on acceptance, then advance address and beat count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
            wlast_err_q  <= 1'b0;
            beat_q       <= '0;
            rr_rd_last   <= 1'b0;
            issue_done_q <= 1'b0;
        end else if (aw_grant) begin
            id_q         <= s_axi.S_AXI_AWID;
            addr_q       <= s_axi.S_AXI_AWADDR;
            len_q        <= s_axi.S_AXI_AWLEN;
            size_q       <= s_axi.S_AXI_AWSIZE;
            burst_q      <= s_axi.S_AXI_AWBURST;
            err_q        <= burst_err(s_axi.S_AXI_AWLEN, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST);
            wlast_err_q  <= 1'b0;
            beat_q       <= '0;
            issue_done_q <= 1'b0;
            if (both_valid) rr_rd_last <= 1'b0;
        end else if (ar_grant) begin
            id_q         <= s_axi.S_AXI_ARID;
            addr_q       <= s_axi.S_AXI_ARADDR;
            len_q        <= s_axi.S_AXI_ARLEN;
            size_q       <= s_axi.S_AXI_ARSIZE;
            burst_q      <= s_axi.S_AXI_ARBURST;
            err_q        <= burst_err(s_axi.S_AXI_ARLEN, s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST);
            wlast_err_q  <= 1'b0;
            beat_q       <= '0;
            issue_done_q <= 1'b0;
            if (both_valid) rr_rd_last <= 1'b1;
        end else if (w_beat) begin
            addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
            beat_q <= beat_q + 8'd1;
            if (s_axi.S_AXI_WLAST != (beat_q == len_q)) wlast_err_q <= 1'b1;
        end else if (rd_issue) begin
            addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
            beat_q <= beat_q + 8'd1;
            if (beat_q == len_q) issue_done_q <= 1'b1;
        end
    end

    // Read return: track the beat in flight and park it in the skid when stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
            s_data  <= '0;
        end else begin
            p_valid <= rd_issue;
            p_last  <= rd_issue && (beat_q == len_q);
            if (p_valid && !s_axi.S_AXI_RREADY) begin
                s_valid <= 1'b1;
                s_last  <= p_last;
                s_data  <= rd_data;
            end else if (s_valid && s_axi.S_AXI_RREADY) begin
                s_valid <= 1'b0;
            end
        end
    end

    // Sideband fields that carry no meaning for an SRAM target
    logic unused_sideband;
    assign unused_sideband = ^{s_axi.S_AXI_AWLOCK, s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWPROT,
                               s_axi.S_AXI_AWQOS, s_axi.S_AXI_AWUSER,
                               s_axi.S_AXI_ARLOCK, s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARPROT,
                               s_axi.S_AXI_ARQOS, s_axi.S_AXI_ARUSER};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural 1-cycle SRAM.
module tb_axi_sram_slave;
    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int MAW = 14;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave_if #(.C_AXI_ID_WIDTH(IDW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW)) bus ();

    logic           mem_req, mem_we;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wstrb;

    axi_sram_slave #(
        .C_AXI_ID_WIDTH(IDW), .C_AXI_DATA_WIDTH(DW),
        .C_AXI_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_axi(bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port SRAM, one cycle read latency
    logic [DW-1:0] sram [0:(1<<MAW)-1];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    int cyc = 0;
    int req_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_req === 1'b1) req_cnt <= req_cnt + 1;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results of the last read burst
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [1:0]  rd_id   [16];
    int          rd_cyc  [16];
    int          rd_n, hs_cyc, first_rv, first_req, hold_bad;
    logic        hs_other;
    // Results of the last write burst
    logic [1:0]  wr_resp, wr_bid;
    int          wr_n, wr_bad;

    task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int t;
        bit done, was_stall;
        logic [31:0] held;
        bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len;
        bus.S_AXI_ARSIZE = size; bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_ARREADY && t < 100);
        check("ar_accept", bus.S_AXI_ARREADY, 1);
        hs_cyc = cyc; hs_other = bus.S_AXI_AWREADY;
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b1;
        rd_n = 0; first_rv = -1; first_req = -1; hold_bad = 0;
        was_stall = 0; held = '0; done = 0; t = 0;
        while (!done && rd_n < 16 && t < 200) begin
            @(negedge clk); t++;
            if (mem_req && first_req < 0) first_req = cyc;
            if (bus.S_AXI_RVALID && first_rv < 0) first_rv = cyc;
            if (was_stall && (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== held)) hold_bad++;
            was_stall = bus.S_AXI_RVALID && !bus.S_AXI_RREADY;
            held = bus.S_AXI_RDATA;
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                rd_data[rd_n] = bus.S_AXI_RDATA; rd_resp[rd_n] = bus.S_AXI_RRESP;
                rd_last[rd_n] = bus.S_AXI_RLAST; rd_id[rd_n] = bus.S_AXI_RID;
                rd_cyc[rd_n] = cyc;
                rd_n++;
                if (bus.S_AXI_RLAST) done = 1;
            end
            @(posedge clk); #1;
            if (toggle && !done) bus.S_AXI_RREADY = ~bus.S_AXI_RREADY;
        end
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, input logic [3:0] strb, input int wlast_at);
        int t;
        bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len;
        bus.S_AXI_AWSIZE = 3'd2; bus.S_AXI_AWBURST = INCR; bus.S_AXI_AWVALID = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_AWREADY && t < 100);
        check("aw_accept", bus.S_AXI_AWREADY, 1);
        hs_other = bus.S_AXI_ARREADY;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0;
        wr_n = 0; wr_bad = 0;
        for (int k = 0; k <= int'(len); k++) begin
            bus.S_AXI_WVALID = 1'b1;
            bus.S_AXI_WDATA = base + k;
            bus.S_AXI_WSTRB = strb;
            bus.S_AXI_WLAST = (wlast_at < 0) ? (k == int'(len)) : (k == wlast_at);
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.S_AXI_WREADY && t < 50);
            if (bus.S_AXI_WREADY) begin
                if (mem_req && mem_we) wr_n++;
                if (mem_wstrb !== strb || mem_wdata !== base + k) wr_bad++;
            end
            @(posedge clk); #1;
        end
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_BVALID && t < 50);
        check("b_valid", bus.S_AXI_BVALID, 1);
        wr_resp = bus.S_AXI_BRESP; wr_bid = bus.S_AXI_BID;
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    int wrap_words [4] = '{'h0E, 'h0F, 'h0C, 'h0D};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, t, stale;
        for (int i = 0; i < (1 << MAW); i++) sram[i] = 32'hC0DE_0000 | i;
        bus.S_AXI_AWLOCK = 0; bus.S_AXI_AWCACHE = 0; bus.S_AXI_AWPROT = 0;
        bus.S_AXI_AWQOS = 0; bus.S_AXI_AWUSER = 0;
        bus.S_AXI_ARLOCK = 0; bus.S_AXI_ARCACHE = 0; bus.S_AXI_ARPROT = 0;
        bus.S_AXI_ARQOS = 0; bus.S_AXI_ARUSER = 0;
        bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0; bus.S_AXI_WLAST = 0; bus.S_AXI_WVALID = 0;
        bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
        // Both address channels request while still in reset
        bus.S_AXI_AWID = 2'd2; bus.S_AXI_AWADDR = 32'h100; bus.S_AXI_AWLEN = 0;
        bus.S_AXI_AWSIZE = 3'd2; bus.S_AXI_AWBURST = INCR; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_ARID = 2'd1; bus.S_AXI_ARADDR = 32'h300; bus.S_AXI_ARLEN = 0;
        bus.S_AXI_ARSIZE = 3'd2; bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY, bus.S_AXI_WREADY,
                                bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_RLAST,
                                mem_req, mem_we}, 0);
        check("reset_rdata", bus.S_AXI_RDATA, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Arbitration after reset: read first, then the pending write
        do_read(2'd1, 32'h300, 8'd0, 3'd2, INCR, 0);
        check("arb1_aw_not_granted", hs_other, 0);
        check("arb1_beats", rd_n, 1);
        check("arb1_rdata", rd_data[0], 32'hC0DE_00C0);
        check("arb1_rid", rd_id[0], 2'd1);
        check("arb1_rlast", rd_last[0], 1);
        do_write(2'd2, 32'h100, 8'd0, 32'hDEAD_BEEF, 4'hF, -1);
        check("wr1_bresp", wr_resp, 2'b00);
        check("wr1_bid", wr_bid, 2'd2);
        check("wr1_mem_writes", wr_n, 1);
        check("wr1_mem_payload_bad", wr_bad, 0);

        // Read back with latency measurement
        do_read(2'd0, 32'h100, 8'd0, 3'd2, INCR, 0);
        check("rd1_rdata", rd_data[0], 32'hDEAD_BEEF);
        check("rd1_rlast", rd_last[0], 1);
        check("rd1_rresp", rd_resp[0], 2'b00);
        check("rd1_req_latency", first_req - hs_cyc, 1);
        check("rd1_rvalid_latency", first_rv - hs_cyc, 2);

        // INCR LEN=7 at full rate
        do_read(2'd2, 32'h200, 8'd7, 3'd2, INCR, 0);
        check("incr_beats", rd_n, 8);
        for (int k = 0; k < 8; k++) begin
            check("incr_data", rd_data[k], 32'hC0DE_0080 + k);
            check("incr_last", rd_last[k], (k == 7));
        end
        check("incr_back_to_back", rd_cyc[7] - rd_cyc[0], 7);

        // Same burst with RREADY toggling
        do_read(2'd2, 32'h200, 8'd7, 3'd2, INCR, 1);
        check("toggle_beats", rd_n, 8);
        for (int k = 0; k < 8; k++) check("toggle_data", rd_data[k], 32'hC0DE_0080 + k);
        check("toggle_hold_bad", hold_bad, 0);

        // WRAP LEN=3 from 0x38
        do_read(2'd1, 32'h38, 8'd3, 3'd2, WRAP, 0);
        check("wrap_beats", rd_n, 4);
        for (int k = 0; k < 4; k++) check("wrap_data", rd_data[k], 32'hC0DE_0000 | wrap_words[k]);

        // WRAP with illegal LEN=2: error burst, no SRAM traffic
        c0 = req_cnt;
        do_read(2'd3, 32'h40, 8'd2, 3'd2, WRAP, 0);
        check("wrap_err_beats", rd_n, 3);
        for (int k = 0; k < 3; k++) begin
            check("wrap_err_resp", rd_resp[k], 2'b10);
            check("wrap_err_data", rd_data[k], 0);
            check("wrap_err_last", rd_last[k], (k == 2));
        end
        check("wrap_err_mem_req", req_cnt - c0, 0);

        // Second contested pair: write wins; early WLAST and partial strobes
        bus.S_AXI_ARID = 2'd2; bus.S_AXI_ARADDR = 32'h400; bus.S_AXI_ARLEN = 8'd3;
        bus.S_AXI_ARSIZE = 3'd2; bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b1;
        do_write(2'd3, 32'h400, 8'd3, 32'h1111_AB00, 4'h3, 1);
        check("arb2_ar_not_granted", hs_other, 0);
        check("wlast_bresp", wr_resp, 2'b10);
        check("wlast_bid", wr_bid, 2'd3);
        check("wlast_mem_writes", wr_n, 4);
        check("wlast_mem_payload_bad", wr_bad, 0);
        do_read(2'd2, 32'h400, 8'd3, 3'd2, INCR, 0);
        check("strb_beats", rd_n, 4);
        for (int k = 0; k < 4; k++) check("strb_merge", rd_data[k], 32'hC0DE_AB00 + k);

        // Reset in the middle of a LEN=7 read
        bus.S_AXI_ARID = 2'd1; bus.S_AXI_ARADDR = 32'h200; bus.S_AXI_ARLEN = 8'd7;
        bus.S_AXI_ARSIZE = 3'd2; bus.S_AXI_ARBURST = INCR; bus.S_AXI_ARVALID = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.S_AXI_ARREADY && t < 100);
        check("mid_ar_accept", bus.S_AXI_ARREADY, 1);
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        n = 0; t = 0;
        while (n < 3 && t < 50) begin
            @(negedge clk); t++;
            if (bus.S_AXI_RVALID) n++;
        end
        check("mid_beats_seen", n, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_WREADY,
                                    bus.S_AXI_BVALID, bus.S_AXI_ARREADY, mem_req}, 0);
        check("mid_reset_rdata", bus.S_AXI_RDATA, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        repeat (6) begin @(negedge clk); if (bus.S_AXI_RVALID) stale++; end
        check("mid_no_stale_beats", stale, 0);
        @(posedge clk); #1 bus.S_AXI_RREADY = 1'b0;
        do_read(2'd0, 32'h100, 8'd0, 3'd2, INCR, 0);
        check("post_reset_beats", rd_n, 1);
        check("post_reset_rdata", rd_data[0], 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
